// File: rtl/pdm_demod.sv
`default_nettype none
// pdm_demod: 1-bit PDM to signed 8-bit PCM decimator with a one-entry valid/ready output
// register and sticky overrun. Define PDM_DEMOD_CIC2_EN to replace the boxcar with a CIC2.
module pdm_demod #(
   parameter int DECIM = 64
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       pdm_in,
   input  logic       tick_in,
   input  logic       enable_in,
   output logic [7:0] level_out,
   output logic       valid_out,
   input  logic       ready_in,
   output logic       overrun_out
);
   localparam int LOG2D = $clog2(DECIM);
`ifdef PDM_DEMOD_CIC2_EN
   localparam int EXP = 2 * LOG2D;
`else
   localparam int EXP = LOG2D;
`endif
   // Window result spans [0, 2^EXP], so one extra bit over EXP.
   localparam int AW  = EXP + 1;
   localparam int DEN = 1 << EXP;
   localparam int LSH = (EXP < 7) ? 7 - EXP : 0;
   localparam int RSH = (EXP > 7) ? EXP - 7 : 0;
   localparam int RW  = EXP + 10;
   localparam logic signed [RW-1:0] MAXV = RW'(127);
   localparam logic signed [RW-1:0] MINV = RW'(-128);

   typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;
   state_t state, state_nxt;

   logic [LOG2D-1:0] tick_cnt;
   logic             step, last, emit, fill_done;
   logic [AW-1:0]    win_sum;

   assign step = tick_in & enable_in;
   assign last = step && (tick_cnt == LOG2D'(DECIM - 1));

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)        tick_cnt <= '0;
      else if (!enable_in) tick_cnt <= '0;
      else if (step)      tick_cnt <= last ? '0 : tick_cnt + 1'b1;
   end

`ifdef PDM_DEMOD_CIC2_EN
   logic [AW-1:0] integ1, integ2, comb_x_d, comb1_d;
   logic [AW-1:0] integ1_nxt, integ2_nxt, comb1;
   logic          fill_one;

   assign integ1_nxt = integ1 + AW'(pdm_in);
   assign integ2_nxt = integ2 + integ1_nxt;
   assign comb1      = integ2_nxt - comb_x_d;
   assign win_sum    = comb1 - comb1_d;
   assign fill_done  = fill_one;
   assign emit       = last & (state == RUN);

   // Integrators and comb delays wrap freely; the comb difference is exact modulo 2^AW.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         integ1   <= '0;
         integ2   <= '0;
         comb_x_d <= '0;
         comb1_d  <= '0;
         fill_one <= 1'b0;
      end else if (!enable_in) begin
         integ1   <= '0;
         integ2   <= '0;
         comb_x_d <= '0;
         comb1_d  <= '0;
         fill_one <= 1'b0;
      end else if (step) begin
         integ1 <= integ1_nxt;
         integ2 <= integ2_nxt;
         if (last) begin
            comb_x_d <= integ2_nxt;
            comb1_d  <= comb1;
            fill_one <= 1'b1;
         end
      end
   end
`else
   logic [AW-1:0] ones;

   assign win_sum   = ones + AW'(pdm_in);
   assign fill_done = 1'b1;
   assign emit      = last;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)         ones <= '0;
      else if (!enable_in) ones <= '0;
      else if (step)       ones <= last ? '0 : win_sum;
   end
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= FILL;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable_in)             state_nxt = FILL;
      else if (last && fill_done) state_nxt = RUN;
   end

   logic signed [RW-1:0] raw, shifted;
   logic [7:0]           sample;

   assign raw     = $signed(RW'({win_sum, 1'b0})) - $signed(RW'(DEN));
   assign shifted = (raw <<< LSH) >>> RSH;

   always_comb begin
      sample = shifted[7:0];
      if (shifted > MAXV)      sample = 8'h7f;
      else if (shifted < MINV) sample = 8'h80;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         level_out   <= '0;
         valid_out   <= 1'b0;
         overrun_out <= 1'b0;
      end else if (emit) begin
         if (!valid_out || ready_in) begin
            level_out <= sample;
            valid_out <= 1'b1;
         end else begin
            overrun_out <= 1'b1;
         end
      end else if (ready_in) begin
         valid_out <= 1'b0;
      end
   end

endmodule
`default_nettype wire
